// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: Avalon-ST style sink stream plus per-frame FFT configuration.
// Ports (signals): sink_valid/sop/eop/error, fftpts, inverse, sample_idx driven by the master;
// sink_ready driven by the slave (downstream FFT).
interface fft_frame_ctrl_if #(parameter int MAX_LOG2 = 10);
  logic                sink_valid;
  logic                sink_ready;
  logic                sink_sop;
  logic                sink_eop;
  logic [1:0]          sink_error;
  logic [MAX_LOG2:0]   fftpts;
  logic                inverse;
  logic [MAX_LOG2-1:0] sample_idx;
  modport master(output sink_valid, sink_sop, sink_eop, sink_error, fftpts, inverse, sample_idx,
                 input sink_ready);
  modport slave(input sink_valid, sink_sop, sink_eop, sink_error, fftpts, inverse, sample_idx,
                output sink_ready);
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: generates framed beat streams (sop..eop, N=2^k) for a streaming FFT.
// Ports: clk, reset_n (sync, active-low), enable, cfg_log2, cfg_inverse, frame_cnt (completed
// frames), bus (fft_frame_ctrl_if.master). Optional inter-frame gap enabled by macro FRAME_GAP_EN.
module fft_frame_ctrl #(
  parameter int MAX_LOG2   = 10,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  cfg_log2,
  input  logic        cfg_inverse,
  output logic [15:0] frame_cnt,
  fft_frame_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef FRAME_GAP_EN
    , GAP
`endif
  } state_t;
`ifdef FRAME_GAP_EN
  localparam bit use_gap = GAP_CYCLES != 0;
  localparam int gw = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  logic [gw-1:0] gap_cnt;
`else
  localparam bit use_gap = 1'b0;
`endif
  localparam logic [3:0] kmax = 4'(MAX_LOG2);
  state_t state;
  logic [3:0] k_eff;
  logic [MAX_LOG2:0] n_new, nxt;
  logic done, start;
  assign k_eff = cfg_log2 < 4'd3 ? 4'd3 : cfg_log2 > kmax ? kmax : cfg_log2;
  assign n_new = (MAX_LOG2+1)'(1) << k_eff;
  assign nxt = {1'b0, bus.sample_idx} + 1'b1;
  assign done = state == RUN && bus.sink_ready && bus.sink_eop;
  // Back-to-back restart happens straight from the eop acceptance when no gap is configured.
  assign start = enable && (state == IDLE || (done && !use_gap));
  assign bus.sink_error = 2'b00;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.sink_valid <= 1'b0;
      bus.sink_sop   <= 1'b0;
      bus.sink_eop   <= 1'b0;
      bus.sample_idx <= '0;
      bus.inverse    <= 1'b0;
      bus.fftpts     <= (MAX_LOG2+1)'(1) << MAX_LOG2;
      frame_cnt      <= '0;
`ifdef FRAME_GAP_EN
      gap_cnt        <= '0;
`endif
    end else begin
      if (done) frame_cnt <= frame_cnt + 16'd1;
      if (start) begin
        state          <= RUN;
        bus.sink_valid <= 1'b1;
        bus.sink_sop   <= 1'b1;
        bus.sink_eop   <= 1'b0;
        bus.sample_idx <= '0;
        bus.fftpts     <= n_new;
        bus.inverse    <= cfg_inverse;
      end else if (state == RUN && bus.sink_ready) begin
        if (bus.sink_eop) begin
          bus.sink_valid <= 1'b0;
          bus.sink_sop   <= 1'b0;
          bus.sink_eop   <= 1'b0;
          bus.sample_idx <= '0;
`ifdef FRAME_GAP_EN
          if (use_gap) begin
            state   <= GAP;
            gap_cnt <= gw'(GAP_CYCLES - 1);
          end else state <= IDLE;
`else
          state <= IDLE;
`endif
        end else begin
          bus.sample_idx <= bus.sample_idx + 1'b1;
          bus.sink_sop   <= 1'b0;
          bus.sink_eop   <= nxt == bus.fftpts - 1'b1;
        end
      end
`ifdef FRAME_GAP_EN
      else if (state == GAP) begin
        if (gap_cnt == '0) state <= IDLE;
        else gap_cnt <= gap_cnt - 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed plus random stimulus checked every cycle against a frame-level model.
module tb_fft_frame_ctrl;
  localparam int ML = 10;
  localparam int G  = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic cfg_inverse = 1'b0;
  logic [3:0] cfg_log2 = 4'd0;
  logic [15:0] frame_cnt;
  int tests = 0;
  int fails = 0;
  bit m_act, m_inv;
  int m_n, m_idx, m_cnt, m_gap;
  fft_frame_ctrl_if #(.MAX_LOG2(ML)) bus();
  fft_frame_ctrl #(.MAX_LOG2(ML), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_log2(cfg_log2),
    .cfg_inverse(cfg_inverse), .frame_cnt(frame_cnt), .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic begin_frame(input int lg, input bit inv);
    int k;
    k = lg < 3 ? 3 : (lg > ML ? ML : lg);
    m_act = 1; m_idx = 0; m_n = 1 << k; m_inv = inv;
  endtask
  task automatic step(input bit rst, input bit en, input int lg, input bit inv, input bit rdy);
    reset_n = rst; enable = en; cfg_log2 = lg[3:0]; cfg_inverse = inv; bus.sink_ready = rdy;
    @(posedge clk);
    if (!rst) begin
      m_act = 0; m_idx = 0; m_cnt = 0; m_inv = 0; m_n = 1 << ML; m_gap = 0;
    end else if (m_act) begin
      if (rdy) begin
        if (m_idx == m_n - 1) begin
          m_cnt = (m_cnt + 1) % 65536;
          m_act = 0; m_idx = 0;
`ifdef FRAME_GAP_EN
          m_gap = G;
          if (G == 0 && en) begin_frame(lg, inv);
`else
          if (en) begin_frame(lg, inv);
`endif
        end else m_idx++;
      end
    end else if (m_gap > 0) m_gap--;
    else if (en) begin_frame(lg, inv);
    #1;
    check("valid", 32'(bus.sink_valid), 32'(m_act));
    check("sop", 32'(bus.sink_sop), 32'(m_act && m_idx == 0));
    check("eop", 32'(bus.sink_eop), 32'(m_act && m_idx == m_n - 1));
    check("idx", 32'(bus.sample_idx), 32'(m_idx));
    check("fftpts", 32'(bus.fftpts), 32'(m_n));
    check("inverse", 32'(bus.inverse), 32'(m_inv));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    check("error", 32'(bus.sink_error), 32'd0);
  endtask
  initial begin
    bus.sink_ready = 1'b0;
    repeat (2) step(0, 0, 0, 0, 0);
    check("rst_fftpts", 32'(bus.fftpts), 32'd1024);
    step(1, 1, 3, 0, 1);
    check("first_sop", 32'(bus.sink_sop), 32'd1);
    check("first_n", 32'(bus.fftpts), 32'd8);
    repeat (12) step(1, 0, 3, 0, 1);
    check("one_frame", 32'(frame_cnt), 32'd1);
    step(1, 1, 3, 1, 1);
    repeat (4) step(1, 0, 5, 0, 1);
    check("stall_idx", 32'(bus.sample_idx), 32'd4);
    repeat (3) step(1, 0, 5, 0, 0);
    check("stall_hold", 32'(bus.sample_idx), 32'd4);
    repeat (8) step(1, 0, 5, 0, 1);
    check("two_frames", 32'(frame_cnt), 32'd2);
    step(1, 1, 0, 0, 1);
    check("clamp_lo", 32'(bus.fftpts), 32'd8);
    repeat (12) step(1, 0, 0, 0, 1);
    step(1, 1, 15, 1, 1);
    check("clamp_hi", 32'(bus.fftpts), 32'd1024);
    repeat (1030) step(1, 0, 15, 0, 1);
    step(1, 1, 3, 0, 1);
    repeat (3) step(1, 1, 3, 0, 1);
    repeat (30) step(1, 1, 4, 0, 1);
    repeat (30) step(1, 0, 4, 0, 1);
    step(1, 1, 3, 0, 1);
    repeat (5) step(1, 0, 3, 0, 1);
    check("pre_rst_idx", 32'(bus.sample_idx), 32'd5);
    step(0, 0, 3, 0, 1);
    check("rst_valid", 32'(bus.sink_valid), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    step(1, 1, 3, 0, 1);
    check("post_rst_sop", 32'(bus.sink_sop), 32'd1);
    repeat (3000) step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 9) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 6),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
